// File: rtl/iact_pkg.sv
// Shared definitions for the iact scratchpad buffer: FSM state encoding and
// the buffer depth derived from the configuration width.
package iact_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_ADVANCE = 2'd2
  } iact_state_e;

  // Number of buffer entries addressable by a cfg_width-bit pointer.
  function automatic int iact_depth(input int cfg_width);
    return 1 << cfg_width;
  endfunction

endpackage

// File: rtl/iact_spad_buffer_if.sv
// Bundle of the upstream write/control signals and the MAC-side read
// handshake for the iact scratchpad buffer. The master drives stimulus and
// accepts words; the slave is the buffer itself.
interface iact_spad_buffer_if #(
  parameter int DATA_WIDTH       = 16,
  parameter int MAX_CONFIG_WIDTH = 5
);

  logic                        wr_en;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic                        clear;
  logic                        start;
  logic [MAX_CONFIG_WIDTH-1:0] filter_size;
  logic                        rd_ready;

  logic                        rd_valid;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        rd_last;
  logic [MAX_CONFIG_WIDTH:0]   count;
  logic                        full;
  logic                        overflow;
  logic                        done;

  modport master (
    output wr_en, wr_data, clear, start, filter_size, rd_ready,
    input  rd_valid, rd_data, rd_last, count, full, overflow, done
  );

  modport slave (
    input  wr_en, wr_data, clear, start, filter_size, rd_ready,
    output rd_valid, rd_data, rd_last, count, full, overflow, done
  );

endinterface

// File: rtl/iact_spad_mem.sv
// Storage array for the iact scratchpad: one synchronous write port and one
// asynchronous (combinational) read port.
module iact_spad_mem
  import iact_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = iact_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Write port; entries are only ever read after being written, so the
  // array carries no reset.
  // NOTE: leaving the array out of reset lets it map onto RAM/latch-array
  // macros; the pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/iact_spad_buffer.sv
// Sliding-window iact scratchpad: a circular buffer filled by the upstream
// FIFO, read out fs words at a time to the MAC, then slid by one word.
module iact_spad_buffer
  import iact_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int MAX_CONFIG_WIDTH = 5
) (
  input logic               clk,
  input logic               rstn,
  iact_spad_buffer_if.slave bus
);

  localparam int                AW        = MAX_CONFIG_WIDTH;
  localparam int                CNT_W     = MAX_CONFIG_WIDTH + 1;
  localparam int                DEPTH     = iact_depth(MAX_CONFIG_WIDTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  iact_state_e           state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         rd_idx_q, rd_idx_d;
  logic [AW-1:0]         fs_q, fs_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic                  full;
  logic                  wr_accept;
  logic                  pop;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  done;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;

  assign full      = (count_q == DEPTH_CNT);
  assign wr_accept = bus.wr_en && !full && !bus.clear;
  // Pointer-width addition wraps modulo DEPTH on its own.
  assign rd_addr   = rd_ptr_q + rd_idx_q;

  iact_spad_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_word)
  );

  // Read-pass FSM: next state, window index, and handshake outputs.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    fs_d     = fs_q;
    pop      = 1'b0;
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.filter_size != '0) &&
            (count_q >= {1'b0, bus.filter_size})) begin
          state_d  = ST_READ;
          fs_d     = bus.filter_size;
          rd_idx_d = '0;
        end
      end
      ST_READ: begin
        rd_valid = 1'b1;
        rd_last  = (rd_idx_q == fs_q - AW'(1));
        if (bus.rd_ready) begin
          if (rd_last) begin
            state_d = ST_ADVANCE;
          end else begin
            rd_idx_d = rd_idx_q + AW'(1);
          end
        end
      end
      ST_ADVANCE: begin
        done    = 1'b1;
        pop     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.clear) begin
      state_d  = ST_IDLE;
      rd_idx_d = '0;
      pop      = 1'b0;
    end
  end

  // Pointer, occupancy and overflow next state; clear flushes the window.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = bus.wr_en && full && !bus.clear;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)       rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_accept, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  // NOTE: non-blocking assignments make every register sample the pre-edge
  // values, so ordering inside this block does not matter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_idx_q   <= '0;
      fs_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_idx_q   <= rd_idx_d;
      fs_q       <= fs_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_valid ? rd_word : '0;
  assign bus.rd_last  = rd_last;
  assign bus.done     = done;
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;

endmodule
